// File: rtl/audio_arb_pkg.sv
// Shared types and defaults for the audio source arbiter.
// The muted handover gap is built only when AUDIO_ARB_GAP_EN is defined.
package audio_arb_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSong,
    StGap,
    StNote,
    StHold
  } arb_state_t;

  localparam int unsigned HoldCyclesDef = 4;
  localparam int unsigned GapCyclesDef  = 2;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/arb_down_counter.sv
// Loadable down-counter timing the GAP and HOLD intervals; reads 0 whenever idle.
module arb_down_counter #(
  parameter int unsigned Width = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             en_i,
  output logic             zero_o
);

  logic [Width-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = '0;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Flags the last counted cycle: the decrement at this edge reaches zero.
  assign zero_o = (cnt_q <= Width'(1));

endmodule

// File: rtl/audio_source_arbiter.sv
// Arbitrates the note and song tone streams onto one registered audio output.
// Define AUDIO_ARB_GAP_EN to insert a muted GAP on every source handover.
module audio_source_arbiter
  import audio_arb_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = HoldCyclesDef,
  parameter int unsigned GAP_CYCLES  = GapCyclesDef
) (
  input  logic CLK,
  input  logic RST,
  input  logic noteReq,
  input  logic songReq,
  input  logic audioNote,
  input  logic audioSong,
  output logic audioSel,
  output logic songPause,
  output logic audioOut
);

  localparam int unsigned CntW = $clog2(max_u(HOLD_CYCLES, GAP_CYCLES) + 1);

  arb_state_t      state_d, state_q;
  logic            audio_d, audio_q;
  logic            cnt_load, cnt_en, cnt_zero;
  logic [CntW-1:0] cnt_load_val;
`ifdef AUDIO_ARB_GAP_EN
  arb_state_t      target_d, target_q;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_en       = 1'b0;
`ifdef AUDIO_ARB_GAP_EN
    target_d     = target_q;
`endif
    case (state_q)
      StIdle: begin
        if (noteReq) begin
          state_d = StNote;
        end else if (songReq) begin
          state_d = StSong;
        end
      end
      StSong: begin
        if (noteReq) begin
`ifdef AUDIO_ARB_GAP_EN
          state_d      = StGap;
          target_d     = StNote;
          cnt_load     = 1'b1;
          cnt_load_val = CntW'(GAP_CYCLES);
`else
          state_d      = StNote;
`endif
        end else if (!songReq) begin
          state_d = StIdle;
        end
      end
`ifdef AUDIO_ARB_GAP_EN
      StGap: begin
        cnt_en = 1'b1;
        // A late note request retargets the gap without restarting its count.
        if (noteReq) begin
          target_d = StNote;
        end
        if (cnt_zero) begin
          if (noteReq || (target_q == StNote)) begin
            state_d = StNote;
          end else if (songReq) begin
            state_d = StSong;
          end else begin
            state_d = StIdle;
          end
        end
      end
`endif
      StNote: begin
        if (!noteReq) begin
          state_d      = StHold;
          cnt_load     = 1'b1;
          cnt_load_val = CntW'(HOLD_CYCLES);
        end
      end
      StHold: begin
        if (noteReq) begin
          state_d = StNote;
        end else begin
          cnt_en = 1'b1;
          if (cnt_zero) begin
            if (songReq) begin
`ifdef AUDIO_ARB_GAP_EN
              state_d      = StGap;
              target_d     = StSong;
              cnt_load     = 1'b1;
              cnt_load_val = CntW'(GAP_CYCLES);
`else
              state_d      = StSong;
`endif
            end else begin
              state_d = StIdle;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    case (state_q)
      StNote, StHold: audio_d = audioNote;
      StSong:         audio_d = audioSong;
      default:        audio_d = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= StIdle;
      audio_q  <= 1'b0;
`ifdef AUDIO_ARB_GAP_EN
      target_q <= StSong;
`endif
    end else begin
      state_q  <= state_d;
      audio_q  <= audio_d;
`ifdef AUDIO_ARB_GAP_EN
      target_q <= target_d;
`endif
    end
  end

  arb_down_counter #(
    .Width (CntW)
  ) u_cnt (
    .clk_i      (CLK),
    .rst_i      (RST),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .en_i       (cnt_en),
    .zero_o     (cnt_zero)
  );

  assign audioSel  = (state_q == StNote) || (state_q == StHold);
  assign songPause = songReq && (state_q != StSong);
  assign audioOut  = audio_q;

endmodule
